// File: rtl/seg7_scan_driver.sv
// Multiplexed hex 7-segment scanner with a double-buffered display register.
// The shown value changes only at frame boundaries, so a new value never tears mid-frame.
module seg7_scan_driver #(
  parameter int NDIG       = 8,
  parameter int SCAN_DIV   = 262144,
  parameter int ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [4*NDIG-1:0] data_in,
  input  logic [NDIG-1:0]   dp_in,
  input  logic              load,
  input  logic              blank_lz,
  input  logic              enable,
  output logic [7:0]        seg,
  output logic [NDIG-1:0]   dig,
  output logic              frame_done
);
  localparam int IW = $clog2(NDIG);
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PMAX  = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]   IMAX  = IW'(NDIG - 1);
  localparam logic [7:0]      SEG_X = (ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;
  localparam logic [NDIG-1:0] DIG_X = (ACTIVE_LOW != 0) ? '0 : '1;

  logic [PW-1:0]     presc;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] staging, disp;
  logic [NDIG-1:0]   stage_dp, disp_dp;
  logic              pending;

  logic              wrap, boundary, blanked;
  logic [3:0]        nib;
  logic [NDIG-1:0]   lz;
  logic [7:0]        seg_nxt;
  logic [NDIG-1:0]   dig_nxt;

  // Active-low a..g patterns; dp is handled separately.
  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
      4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
      4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
      4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
      4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
      4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
      4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
      4'hE: decode = 7'h06;  default: decode = 7'h0E;
    endcase
  endfunction

  // lz[i]: nibble i and every higher nibble are zero
  for (genvar i = 0; i < NDIG; i++) begin : g_lz
    assign lz[i] = (disp[4*NDIG-1:4*i] == '0);
  end

  always_comb begin
    wrap     = enable && (presc == PMAX);
    boundary = wrap && (idx == '0);
    nib      = disp[4*idx +: 4];
    blanked  = blank_lz && (idx != '0) && lz[idx];
    seg_nxt  = {~disp_dp[idx], blanked ? 7'h7F : decode(nib)};
    dig_nxt  = ~(NDIG'(1) << idx);
    if (!enable) begin
      seg_nxt = '1;
      dig_nxt = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc      <= '0;
      idx        <= IMAX;
      staging    <= '0;
      stage_dp   <= '0;
      disp       <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
      seg        <= 8'hFF ^ SEG_X;
      dig        <= '1 ^ DIG_X;
      frame_done <= 1'b0;
    end else begin
      if (enable) begin
        presc <= wrap ? '0 : presc + 1'b1;
        if (wrap) idx <= (idx == '0) ? IMAX : idx - 1'b1;
      end
      // A load on the boundary bypasses staging and lands directly in the new frame.
      if (load && boundary) begin
        disp    <= data_in;
        disp_dp <= dp_in;
        pending <= 1'b0;
      end else if (load) begin
        staging  <= data_in;
        stage_dp <= dp_in;
        pending  <= 1'b1;
      end else if (boundary && pending) begin
        disp    <= staging;
        disp_dp <= stage_dp;
        pending <= 1'b0;
      end
      seg        <= seg_nxt ^ SEG_X;
      dig        <= dig_nxt ^ DIG_X;
      frame_done <= boundary;
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (NDIG=4, SCAN_DIV=4, active-low): directed scenarios,
// a decode vector table and randomized traffic, all checked against a frame-time model.
module tb_seg7_scan_driver;
  localparam int NDIG  = 4;
  localparam int SD    = 4;
  localparam int FRAME = NDIG * SD;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0, blank_lz = 1'b0, enable = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  seg7_scan_driver #(.NDIG(NDIG), .SCAN_DIV(SD), .ACTIVE_LOW(1)) dut (
    .clk(clk), .rstn(rstn), .data_in(data_in), .dp_in(dp_in), .load(load),
    .blank_lz(blank_lz), .enable(enable), .seg(seg), .dig(dig), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  bit saw_5 = 1'b0;

  logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    logic [3:0] nib;
    logic [7:0] seg;
  } vec_t;
  vec_t vecs [16];

  // Model: time is counted in enabled cycles since reset; the lit digit and the
  // frame boundary follow from plain division of that count.
  int          t = 0;
  logic [15:0] m_stag = '0, m_disp = '0;
  logic [3:0]  m_sdp = '0, m_ddp = '0;
  bit          m_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    int d;
    bit bnd;
    logic [3:0] nib;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_fd;
    if (!rstn) begin
      e_seg = 8'hFF; e_dig = 4'hF; e_fd = 1'b0;
      t = 0; m_stag = '0; m_disp = '0; m_sdp = '0; m_ddp = '0; m_pend = 1'b0;
    end else begin
      d   = NDIG - 1 - (t / SD) % NDIG;
      bnd = enable && (t % FRAME == FRAME - 1);
      if (enable) begin
        nib   = 4'(m_disp >> (4 * d));
        e_seg = seg_tab[nib];
        if (blank_lz && d > 0 && (m_disp >> (4 * d)) == 0) e_seg = e_seg | 8'h7F;
        if (m_ddp[d]) e_seg[7] = 1'b0;
        e_dig = ~(4'b0001 << d);
      end else begin
        e_seg = 8'hFF; e_dig = 4'hF;
      end
      e_fd = bnd;
      if (load && bnd) begin
        m_disp = data_in; m_ddp = dp_in; m_pend = 1'b0;
      end else if (load) begin
        m_stag = data_in; m_sdp = dp_in; m_pend = 1'b1;
      end else if (bnd && m_pend) begin
        m_disp = m_stag; m_ddp = m_sdp; m_pend = 1'b0;
      end
      if (enable) t++;
    end
    @(posedge clk);
    #1;
    if (seg == 8'h92) saw_5 = 1'b1;
    check("model_seg", {24'd0, seg}, {24'd0, e_seg});
    check("model_dig", {28'd0, dig}, {28'd0, e_dig});
    check("model_frame_done", {31'd0, frame_done}, {31'd0, e_fd});
  endtask

  task automatic wait_fd();
    bit got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      tick();
      got = frame_done;
    end
    check("frame_done_wait", {31'd0, got}, 32'd1);
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] dp);
    data_in = v; dp_in = dp; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // After a frame_done, check one full frame against four per-digit seg values.
  task automatic check_frame(input string name, input logic [31:0] s3, s2, s1, s0);
    logic [31:0] exp_s [4];
    exp_s = '{s3, s2, s1, s0};
    for (int k = 0; k < FRAME; k++) begin
      tick();
      check(name, {24'd0, seg}, exp_s[k / SD]);
      check({name, "_dig"}, {28'd0, dig}, {28'd0, ~(4'b1000 >> (k / SD))});
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) vecs[i] = '{4'(i), 8'h00};
    vecs[0].seg  = 8'hC0; vecs[1].seg  = 8'hF9; vecs[2].seg  = 8'hA4; vecs[3].seg  = 8'hB0;
    vecs[4].seg  = 8'h99; vecs[5].seg  = 8'h92; vecs[6].seg  = 8'h82; vecs[7].seg  = 8'hF8;
    vecs[8].seg  = 8'h80; vecs[9].seg  = 8'h90; vecs[10].seg = 8'h88; vecs[11].seg = 8'h83;
    vecs[12].seg = 8'hC6; vecs[13].seg = 8'hA1; vecs[14].seg = 8'h86; vecs[15].seg = 8'h8E;

    // 1. reset, then release
    repeat (3) tick();
    check("rst_seg", {24'd0, seg}, 32'hFF);
    check("rst_dig", {28'd0, dig}, 32'hF);
    check("rst_fd", {31'd0, frame_done}, 32'd0);
    rstn = 1'b1; enable = 1'b1;
    tick();
    check("first_dig", {28'd0, dig}, 32'h7);
    check("first_seg", {24'd0, seg}, 32'hC0);

    // 2. basic scan order and frame period
    load_val(16'h12AF, 4'h0);
    wait_fd();
    check_frame("scan_12af", 32'hF9, 32'hA4, 32'h88, 32'h8E);
    check("fd_period", {31'd0, frame_done}, 32'd1);

    // 3. tear-free update; 5555 is overwritten before the boundary
    saw_5 = 1'b0;
    repeat (5) tick();
    load_val(16'h5555, 4'h0);
    repeat (2) tick();
    load_val(16'h7777, 4'h0);
    wait_fd();
    check("no_5555_shown", {31'd0, saw_5}, 32'd0);
    check_frame("tear_free", 32'hF8, 32'hF8, 32'hF8, 32'hF8);

    // 4. leading-zero blanking
    blank_lz = 1'b1;
    load_val(16'h0030, 4'h0);
    wait_fd();
    check_frame("blank_0030", 32'hFF, 32'hFF, 32'hB0, 32'hC0);
    load_val(16'h0000, 4'h0);
    wait_fd();
    check_frame("blank_zero", 32'hFF, 32'hFF, 32'hFF, 32'hC0);

    // 5. decimal point
    blank_lz = 1'b0;
    load_val(16'h0030, 4'b0010);
    wait_fd();
    check_frame("dp_digit1", 32'hC0, 32'hC0, 32'h30, 32'hC0);

    // 6. freeze mid-digit, resume, then reset mid-frame
    wait_fd();
    repeat (2) tick();
    enable = 1'b0;
    tick();
    check("frz_dig", {28'd0, dig}, 32'hF);
    check("frz_seg", {24'd0, seg}, 32'hFF);
    tick();
    enable = 1'b1;
    tick();
    check("resume_dig_a", {28'd0, dig}, 32'h7);
    tick();
    check("resume_dig_b", {28'd0, dig}, 32'h7);
    tick();
    check("resume_next", {28'd0, dig}, 32'hB);
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    check("midrst_seg", {24'd0, seg}, 32'hFF);
    check("midrst_dig", {28'd0, dig}, 32'hF);
    rstn = 1'b1;
    tick();
    check("midrst_rel_dig", {28'd0, dig}, 32'h7);
    check("midrst_rel_seg", {24'd0, seg}, 32'hC0);

    // Decode table: each hex value on all four digits
    for (int i = 0; i < 16; i++) begin
      load_val({4{vecs[i].nib}}, 4'h0);
      wait_fd();
      tick();
      check("decode", {24'd0, seg}, {24'd0, vecs[i].seg});
    end

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      load     = ($urandom_range(0, 7) == 0);
      enable   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) blank_lz = ~blank_lz;
      rstn     = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00FF;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
